// File: rtl/ir_transmitter.sv
// Pulse-width-coded IR frame serialiser with 40 kHz carrier for the rover move command.
// Define IR_PARITY_EN to append an even-parity 13th bit to every frame.
module ir_transmitter #(
    parameter int UNIT_CYCLES  = 16200,
    parameter int CARRIER_HALF = 337,
    parameter int START_UNITS  = 4,
    parameter int GAP_UNITS    = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        transmit_ir,
    input  logic [11:0] move_command,
    output logic        ir_out,
    output logic        ir_envelope,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] SPACE      = 3'd2;
    localparam logic [2:0] BURST      = 3'd3;
    localparam logic [2:0] INTERFRAME = 3'd4;

`ifdef IR_PARITY_EN
    localparam int DATA_BITS = 13;
`else
    localparam int DATA_BITS = 12;
`endif

    localparam int UNIT_BITS  = ($clog2(UNIT_CYCLES) > 16) ? $clog2(UNIT_CYCLES) : 16;
    localparam int MAX_UNITS  = (GAP_UNITS > START_UNITS) ? GAP_UNITS : START_UNITS;
    localparam int PHASE_BITS = ($clog2(MAX_UNITS + 1) > 5) ? $clog2(MAX_UNITS + 1) : 5;
    localparam int CAR_BITS   = ($clog2(CARRIER_HALF) > 0) ? $clog2(CARRIER_HALF) : 1;

    localparam logic [UNIT_BITS-1:0] UNIT_LAST = UNIT_BITS'(UNIT_CYCLES - 1);
    localparam logic [CAR_BITS-1:0]  CAR_LAST  = CAR_BITS'(CARRIER_HALF - 1);
    localparam logic [3:0]           LAST_BIT  = 4'(DATA_BITS - 1);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [UNIT_BITS-1:0]  unit_cnt;
    logic [PHASE_BITS-1:0] phase_cnt;
    logic [PHASE_BITS-1:0] phase_len;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  latch_word;
    logic [3:0]            bit_idx;
    logic [CAR_BITS-1:0]   car_cnt;
    logic [CAR_BITS-1:0]   car_cnt_next;
    logic                  carrier;
    logic                  carrier_next;
    logic                  phase_end;
    logic                  load;
    logic                  shift;
    logic                  done_next;
    logic                  env_next;

`ifdef IR_PARITY_EN
    assign latch_word = {^move_command, move_command};
`else
    assign latch_word = move_command;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        phase_len = PHASE_BITS'(1);
        case (state)
            START:      phase_len = PHASE_BITS'(START_UNITS);
            SPACE:      phase_len = PHASE_BITS'(1);
            BURST:      phase_len = shift_reg[0] ? PHASE_BITS'(2) : PHASE_BITS'(1);
            INTERFRAME: phase_len = PHASE_BITS'(GAP_UNITS);
            default:    phase_len = PHASE_BITS'(1);
        endcase
    end

    assign phase_end = (unit_cnt == UNIT_LAST) && (phase_cnt == phase_len - PHASE_BITS'(1));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (transmit_ir) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                if (phase_end) state_next = SPACE;
            end
            SPACE: begin
                if (phase_end) state_next = BURST;
            end
            BURST: begin
                if (phase_end) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next = INTERFRAME;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SPACE;
                        shift      = 1'b1;
                    end
                end
            end
            INTERFRAME: begin
                // Back-to-back frames skip IDLE so the repeat spacing stays exactly one gap
                if (phase_end) begin
                    if (transmit_ir) begin
                        state_next = START;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign env_next = (state_next == START) || (state_next == BURST);

    // Carrier phase is re-anchored on each envelope rise so every burst opens with a high half-cycle
    always_comb begin
        car_cnt_next = car_cnt;
        carrier_next = carrier;
        if (env_next && !ir_envelope) begin
            car_cnt_next = '0;
            carrier_next = 1'b1;
        end else if (car_cnt == CAR_LAST) begin
            car_cnt_next = '0;
            carrier_next = ~carrier;
        end else begin
            car_cnt_next = car_cnt + CAR_BITS'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            unit_cnt    <= '0;
            phase_cnt   <= '0;
            shift_reg   <= '0;
            bit_idx     <= '0;
            car_cnt     <= '0;
            carrier     <= 1'b0;
            ir_envelope <= 1'b0;
            ir_out      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            ir_envelope <= env_next;
            ir_out      <= env_next & carrier_next;
            carrier     <= carrier_next;
            car_cnt     <= car_cnt_next;
            frame_done  <= done_next;

            if (phase_end || state == IDLE) begin
                unit_cnt  <= '0;
                phase_cnt <= '0;
            end else if (unit_cnt == UNIT_LAST) begin
                unit_cnt  <= '0;
                phase_cnt <= phase_cnt + PHASE_BITS'(1);
            end else begin
                unit_cnt <= unit_cnt + UNIT_BITS'(1);
            end

            if (load) begin
                shift_reg <= latch_word;
                bit_idx   <= 4'd0;
            end else if (shift) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 4'd1;
            end
        end
    end

endmodule

// File: doc/ir_transmitter.md
Name: ir_transmitter

Overview:
- Downstream of the main controller. Serialises the 12-bit rover move command onto the IR LED as a pulse-width-coded, 40 kHz-modulated frame.
- Frame format: start burst, then 12 data bits LSB first. Each bit is one unit of space followed by a burst of 1 unit (0) or 2 units (1).
- Frames repeat, with an inter-frame gap, for as long as the transmit level is held. This covers dropped frames on the rover receiver.

Parameters:
- UNIT_CYCLES, 16200: clocks per timing unit (600 us at 27 MHz).
- CARRIER_HALF, 337: clocks per carrier half-period (about 40 kHz at 27 MHz).
- START_UNITS, 4: start-burst length in units.
- GAP_UNITS, 20: inter-frame space in units.

Ports:
- clock  in  1  system clock (27 MHz)
- reset  in  1  asynchronous, active-high reset
- transmit_ir  in  1  level request; frames repeat while high
- move_command  in  12  command word: [7:0] distance, [11:8] angle
- ir_out  out  1  modulated LED drive
- ir_envelope  out  1  unmodulated burst envelope (debug)
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse when the last data burst ends

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0; shift register 0.
- States: IDLE, START, SPACE, BURST, INTERFRAME.
- IDLE:
  - On transmit_ir=1, latch move_command into the shift register, set bit_idx=0, and go to START.
  - ir_envelope rises on the next clock edge.
  - move_command is sampled only at frame start; changes mid-frame are ignored.
- START: envelope high for START_UNITS*UNIT_CYCLES clocks, then go to SPACE.
- SPACE: envelope low for UNIT_CYCLES, then go to BURST.
- BURST:
  - Envelope high for UNIT_CYCLES if the current bit is 0, or 2*UNIT_CYCLES if it is 1.
  - At the end of the burst: if bit_idx==11, pulse frame_done and go to INTERFRAME. Otherwise shift right, increment bit_idx, and go to SPACE.
- INTERFRAME:
  - Envelope low for GAP_UNITS*UNIT_CYCLES.
  - At the end: if transmit_ir=1, re-latch move_command and go to START directly, with no IDLE cycle. Otherwise go to IDLE.
- Dropping transmit_ir mid-frame: never truncates. The current frame and its inter-frame gap complete, then the block returns to IDLE.
- Carrier:
  - The carrier counter restarts at 0 on every envelope rising edge.
  - The carrier is high for the first CARRIER_HALF clocks, then toggles every CARRIER_HALF clocks.
  - ir_out = envelope AND carrier. ir_out is 0 whenever the envelope is 0.
- Counters:
  - Unit counter counts 0..UNIT_CYCLES-1; a unit counter is a 16-bit minimum.
  - Phase unit count is at most GAP_UNITS, in a 5-bit minimum.
  - No wrap-around is permitted within a phase.
- Frame length (data): START_UNITS + 12 + (number of ones) + 12 units.
- Reset mid-frame: ir_out and ir_envelope drop to 0 immediately (asynchronously), no frame_done is issued, and the block returns to IDLE.
- Registration: all outputs are registered. busy is combinational from state only.

Optional Feature:
- Macro: IR_PARITY_EN.
- Defined:
  - A 13th bit is sent after bit 11: even parity, the XOR of all 12 latched bits.
  - frame_done pulses at the end of the parity burst.
  - bit_idx terminates at 12.
- Undefined: exactly 12 bits are sent and no parity logic is built.

Test Plan (UNIT_CYCLES=4, CARRIER_HALF=1, START_UNITS=4, GAP_UNITS=20; IR_PARITY_EN undefined unless stated):
- Orientation move:
  - Stimulus: move_command=12'h010, transmit_ir held high for 1 cycle at t0.
  - Required: envelope high for cycles t0+1..t0+16; bit 4 burst is 8 cycles, all other bursts 4 cycles.
  - Required: frame_done at the end of unit 29 (t0+116); busy falls 80 cycles later; exactly one frame sent.
- Repeat frames:
  - Stimulus: transmit_ir held high through two full frames, move_command changed from 12'h010 to 12'h3A5 mid frame 1.
  - Required: frame 1 encodes 010; frame 2 encodes 3A5; no IDLE cycle between the frames.
- Carrier:
  - Stimulus: any burst.
  - Required: ir_out follows the pattern 1,0,1,0 starting at each envelope rise; ir_out is always 0 during SPACE and INTERFRAME.
- Async reset mid-frame:
  - Stimulus: assert reset during BURST of bit 6, between clock edges.
  - Required: ir_out, ir_envelope and busy go to 0 before the next edge; no frame_done; after release, a new transmit_ir starts a clean frame.
- Parity (IR_PARITY_EN defined):
  - Stimulus: move_command=12'h007.
  - Required: 13th burst is 8 cycles (parity 1); frame_done follows the 13th burst.
  - Stimulus: move_command=12'h003.
  - Required: 13th burst is 4 cycles (parity 0).
- All-zero and all-one commands:
  - Stimulus: 12'h000 and 12'hFFF.
  - Required: frame_done at 28 and 40 units respectively after the envelope rise.
